// File: rtl/icache_param.sv
// icache_param: direct-mapped, read-only instruction cache between the fetch
// stage and the memory arbiter. The number of sets and the number of words per
// block are set by parameters. A miss starts a multi-beat refill. inval clears
// every block in one cycle. miss_cnt is a saturating count of misses.
//
// Ports
//   CLK, nRST           clock (rising edge); asynchronous active-low reset
//   imemREN, imemaddr   fetch request and byte address (bits [1:0] ignored)
//   ihit, imemload      requested word valid this cycle, instruction word
//   inval               invalidate all blocks
//   iREN, iaddr         memory read request and word address
//   iwait, iload        memory busy, memory read data
//   miss_cnt            saturating miss count
//   dbg_state           current FSM state (0 = IDLE_I, 1 = LD)
//
// Memory handshake: iREN is the request and iwait is its inverse ready. A beat
// is transferred on every rising edge where iREN && !iwait; iload is sampled
// on that edge. iaddr stays stable while iREN is high and iwait is high.
module icache_param #(
    parameter int SETS   = 16,
    parameter int WORDS  = 2,
    parameter int MISS_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [31:0]       imemaddr,
    output logic              ihit,
    output logic [31:0]       imemload,
    input  logic              inval,
    output logic              iREN,
    output logic [31:0]       iaddr,
    input  logic              iwait,
    input  logic [31:0]       iload,
    output logic [MISS_W-1:0] miss_cnt,
    output logic              dbg_state
);

    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = 30 - OB - IB;
    // When WORDS=1 there is no offset field. Keep a 1-bit beat that never
    // leaves 0.
    localparam int BW = (OB == 0) ? 1 : OB;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);

    typedef enum logic {
        IDLE_I = 1'b0,
        LD     = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [31:0]    data_mem [SETS][WORDS];
    logic [TB-1:0]  tag_mem  [SETS];
    logic [SETS-1:0] valid;

    logic [TB-1:0]  rtag;
    logic [IB-1:0]  ridx;
    logic [BW-1:0]  beat;

    logic [TB-1:0]  req_tag;
    logic [IB-1:0]  req_idx;
    logic [BW-1:0]  req_off;
    logic           hit_raw;
    logic           miss;
    logic           fill_done;
    logic           unused_addr_bits;

    assign req_tag = imemaddr[31 -: TB];
    assign req_idx = imemaddr[2 + OB +: IB];
    assign unused_addr_bits = ^imemaddr[1:0];

    generate
        if (OB == 0) begin : g_no_off
            assign req_off = '0;
            assign iaddr   = {rtag, ridx, 2'b00};
        end else begin : g_off
            assign req_off = imemaddr[2 +: OB];
            assign iaddr   = {rtag, ridx, beat, 2'b00};
        end
    endgenerate

    assign hit_raw   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign imemload  = data_mem[req_idx][req_off];
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        ihit      = 1'b0;
        iREN      = 1'b0;
        miss      = 1'b0;
        fill_done = 1'b0;
        case (state_q)
            IDLE_I: begin
                ihit = imemREN && hit_raw && !inval;
                miss = imemREN && !hit_raw && !inval;
                if (miss) state_d = LD;
            end
            LD: begin
                iREN      = 1'b1;
                fill_done = !iwait && (beat == LAST_BEAT);
                if (fill_done) state_d = IDLE_I;
            end
            default: state_d = IDLE_I;
        endcase
        // Invalidate wins over everything, including a fill that completes
        // on the same edge.
        if (inval) state_d = IDLE_I;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE_I;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid    <= '0;
            beat     <= '0;
            miss_cnt <= '0;
            rtag     <= '0;
            ridx     <= '0;
        end else if (inval) begin
            valid <= '0;
            beat  <= '0;
        end else if (miss) begin
            rtag           <= req_tag;
            ridx           <= req_idx;
            valid[req_idx] <= 1'b0;
            beat           <= '0;
            if (miss_cnt != '1) miss_cnt <= miss_cnt + MISS_W'(1);
        end else if (state_q == LD && !iwait) begin
            if (fill_done) begin
                valid[ridx] <= 1'b1;
                beat        <= '0;
            end else begin
                beat <= beat + BW'(1);
            end
        end
    end

    // The data and tag arrays have no reset. A block only becomes usable once
    // its valid bit is set.
    always_ff @(posedge CLK) begin
        if (state_q == LD && !iwait) data_mem[ridx][beat] <= iload;
        if (fill_done && !inval) tag_mem[ridx] <= rtag;
    end

endmodule

// File: tb/tb_icache_param.sv
// Testbench for icache_param with SETS=16 and WORDS=2. A second instance with
// MISS_W=2 shares the same stimulus so that its miss counter saturates.
module tb_icache_param;

    localparam int SETS  = 16;
    localparam int WORDS = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        inval;
    logic        iwait;
    logic [31:0] iload;

    logic        ihit, iREN, dbg_state;
    logic [31:0] imemload, iaddr;
    logic [15:0] miss_cnt;

    logic        s_ihit, s_iREN, s_dbg_state;
    logic [31:0] s_imemload, s_iaddr;
    logic [1:0]  s_miss_cnt;

    icache_param #(.SETS(SETS), .WORDS(WORDS), .MISS_W(16)) u_dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .inval(inval), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload), .miss_cnt(miss_cnt),
        .dbg_state(dbg_state)
    );

    icache_param #(.SETS(SETS), .WORDS(WORDS), .MISS_W(2)) u_sat (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(s_ihit), .imemload(s_imemload), .inval(inval), .iREN(s_iREN),
        .iaddr(s_iaddr), .iwait(iwait), .iload(iload), .miss_cnt(s_miss_cnt),
        .dbg_state(s_dbg_state)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: for each set, which block number (byte address /
    // block size) it holds, if any, and the total number of misses.
    bit          mvalid [SETS];
    logic [31:0] mblk   [SETS];
    int          mcount;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a + 32'h60) ^ ({8'h00, a[31:8]} << 16);
    endfunction

    function automatic logic [31:0] sat3(input int n);
        return (n > 3) ? 32'd3 : 32'(n);
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a / (4 * WORDS)) % SETS);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
    endtask

    // Serves a refill of the block holding addr. Each beat has `waits` busy
    // cycles and then one accept cycle.
    task automatic refill(input logic [31:0] addr, input int waits,
                          input bit drop, input bit inval_last);
        logic [31:0] base;
        int idx;
        base = addr & ~32'(4 * WORDS - 1);
        idx  = set_of(addr);
        for (int b = 0; b < WORDS; b++) begin
            for (int w = 0; w < waits; w++) begin
                @(negedge CLK);
                if (drop && b > 0) begin
                    imemREN  = 1'b0;
                    imemaddr = $urandom;
                end
                iwait = 1'b1;
                #1;
                check("ld_wait_iren", iREN, 1);
                check("ld_wait_iaddr", iaddr, base + 32'(4 * b));
                check("ld_wait_ihit", ihit, 0);
                check("ld_miss_cnt", miss_cnt, 32'(mcount));
                check("ld_sat_cnt", s_miss_cnt, sat3(mcount));
            end
            @(negedge CLK);
            if (drop && b > 0) begin
                imemREN  = 1'b0;
                imemaddr = $urandom;
            end
            iwait = 1'b0;
            iload = mem_word(base + 32'(4 * b));
            if (inval_last && b == WORDS - 1) inval = 1'b1;
            #1;
            check("ld_acc_iren", iREN, 1);
            check("ld_acc_iaddr", iaddr, base + 32'(4 * b));
            check("ld_acc_ihit", ihit, 0);
        end
        if (inval_last) begin
            model_clear();
        end else begin
            mvalid[idx] = 1'b1;
            mblk[idx]   = addr / (4 * WORDS);
        end
        @(negedge CLK);
        iwait = 1'b1;
        inval = 1'b0;
        if (inval_last) imemREN = 1'b0;
        #1;
        check("post_iren", iREN, 0);
        check("post_state", dbg_state, 0);
        if (imemREN) begin
            check("retry_hit", ihit, 1);
            check("retry_data", imemload, mem_word({addr[31:2], 2'b00}));
        end else begin
            check("post_ihit", ihit, 0);
        end
    endtask

    task automatic access(input logic [31:0] addr, input int waits,
                          input bit drop, input bit inval_last);
        int idx;
        bit exp_hit;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = addr;
        inval    = 1'b0;
        iwait    = 1'b1;
        #1;
        idx     = set_of(addr);
        exp_hit = mvalid[idx] && (mblk[idx] == addr / (4 * WORDS));
        check("acc_state", dbg_state, 0);
        check("acc_iren", iREN, 0);
        check("acc_ihit", ihit, 32'(exp_hit));
        check("acc_sat_ihit", s_ihit, 32'(exp_hit));
        if (exp_hit) check("acc_data", imemload, mem_word({addr[31:2], 2'b00}));
        check("acc_miss_cnt", miss_cnt, 32'(mcount));
        check("acc_sat_cnt", s_miss_cnt, sat3(mcount));
        if (!exp_hit) begin
            mcount++;
            refill(addr, waits, drop, inval_last);
        end
    endtask

    task automatic inval_pulse();
        @(negedge CLK);
        inval    = 1'b1;
        imemREN  = 1'($urandom_range(0, 1));
        imemaddr = $urandom;
        #1;
        check("inval_ihit", ihit, 0);
        check("inval_iren", iREN, 0);
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        inval    = 1'b0;
        iwait    = 1'b1;
        iload    = '0;
        mcount   = 0;
        model_clear();
        for (int i = 0; i < SETS; i++) mblk[i] = '0;

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rst_iren", iREN, 0);
        check("rst_ihit", ihit, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        check("rst_state", dbg_state, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Cold miss with two busy cycles per beat, then hits on both words
        access(32'h40, 2, 0, 0);
        check("t1_data_a0", imemload, 32'hA0);
        access(32'h44, 0, 0, 0);
        check("t1_data_a4", imemload, 32'hA4);
        check("t1_miss_cnt", miss_cnt, 1);

        // Conflict eviction on set 8
        access(32'h440, 1, 0, 0);
        access(32'h40, 0, 0, 0);
        check("t2_miss_cnt", miss_cnt, 3);

        // Request withdrawn after beat 0; the block still completes
        access(32'h80, 1, 1, 0);
        access(32'h84, 0, 0, 0);
        check("t3_hit_84", ihit, 1);

        // Invalidate pulse, then inval on the final-beat cycle
        access(32'h40, 0, 0, 0);
        inval_pulse();
        access(32'h40, 0, 0, 0);
        access(32'h100, 0, 0, 1);
        access(32'h100, 1, 0, 0);

        // Saturation of the 2-bit counter
        @(negedge CLK);
        imemREN = 1'b0;
        #1;
        check("t6_miss_cnt", miss_cnt, 7);
        check("t6_sat_stick", s_miss_cnt, 3);

        // Reset in the middle of a refill
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h200;
        iwait    = 1'b1;
        #1;
        check("t5_miss_ihit", ihit, 0);
        @(negedge CLK);
        #1;
        check("t5_ld_iren", iREN, 1);
        nRST = 1'b0;
        #1;
        check("t5_rst_iren", iREN, 0);
        check("t5_rst_cnt", miss_cnt, 0);
        check("t5_rst_sat", s_miss_cnt, 0);
        check("t5_rst_state", dbg_state, 0);
        mcount = 0;
        model_clear();
        @(negedge CLK);
        imemREN = 1'b0;
        nRST    = 1'b1;
        access(32'h200, 0, 0, 0);
        check("t5_cnt_after", miss_cnt, 1);

        // Random mix against the reference model
        for (int n = 0; n < 200; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 15)) << 3)
              | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
            if (r == 0) inval_pulse();
            else access(a, $urandom_range(0, 2), r == 1, r == 2);
        end

        @(negedge CLK);
        imemREN = 1'b0;
        #1;
        check("end_miss_cnt", miss_cnt, 32'(mcount));
        check("end_sat_cnt", s_miss_cnt, sat3(mcount));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
